ext_mem_arbiter: RTL

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

---
 rtl/ext_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ext_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ExtMemArbiter
// Shares a single external memory bus between the fetch stage (program
// memory) and the execute stage (data memory). Addresses with a non-zero
// top nibble live on the external bus and take WAIT_CYCLES+1 bus cycles;
// everything else is internal and never stalls. While an external access
// is in flight the pipeline stage enables are throttled so the requesting
// stage waits for its data.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pm_req       fetch stage requests program memory
//   pm_add       program-memory address
//   dm_req       execute stage requests data memory
//   dm_add       data-memory address
//   rwb          data access direction (1 read, 0 write)
//   ext_cs       external bus access in progress
//   ext_add      external bus address (held for the whole access)
//   ext_rwb      external bus direction (1 read, 0 write)
//   fetch_en     fetch stage advances
//   decode_en    decode stage advances
//   execute_en   execute stage advances
//   execute1_en  second execute stage advances
//   bubble       decode-to-execute register loads a NOP
// ---------------------------------------------------------------------------
module ext_mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pm_req,
    input  logic [15:0] pm_add,
    input  logic        dm_req,
    input  logic [15:0] dm_add,
    input  logic        rwb,
    output logic        ext_cs,
    output logic [15:0] ext_add,
    output logic        ext_rwb,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        execute1_en,
    output logic        bubble
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_WAIT = 2'd1,
        PM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] ext_add_q, ext_add_d;
    logic        ext_rwb_q, ext_rwb_d;

    logic dmExt;
    logic pmExt;
    logic cntZero;

    // An access is external whenever the top nibble of its address is set.
    assign dmExt   = dm_req & (dm_add[15:12] != 4'h0);
    assign pmExt   = pm_req & (pm_add[15:12] != 4'h0);
    assign cntZero = (cnt_q == 4'd0);

    // State register together with the bus-side latches. Reset is
    // asynchronous so an access in flight is dropped the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ext_add_q <= 16'h0000;
            ext_rwb_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ext_add_q <= ext_add_d;
            ext_rwb_q <= ext_rwb_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so the address
    // and direction captured on entry to a WAIT state stay fixed until the
    // access finishes. Data accesses win over fetches when both arrive.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ext_add_d = ext_add_q;
        ext_rwb_d = ext_rwb_q;
        case (state_q)
            IDLE: begin
                if (dmExt) begin
                    state_d   = DM_WAIT;
                    cnt_d     = WAIT_INIT;
                    ext_add_d = dm_add;
                    ext_rwb_d = rwb;
                end else if (pmExt) begin
                    state_d   = PM_WAIT;
                    cnt_d     = WAIT_INIT;
                    ext_add_d = pm_add;
                    ext_rwb_d = 1'b1;
                end
            end
            DM_WAIT, PM_WAIT: begin
                if (cntZero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. Everything is forced low while rst is high so the
    // pipeline freezes immediately, without waiting for a clock edge.
    // During a fetch wait the execute side keeps running on bubbles unless
    // the execute stage itself wants the (busy) external bus.
    always_comb begin
        ext_cs      = 1'b0;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        execute_en  = 1'b0;
        execute1_en = 1'b0;
        bubble      = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (!dmExt && !pmExt) begin
                        fetch_en    = 1'b1;
                        decode_en   = 1'b1;
                        execute_en  = 1'b1;
                        execute1_en = 1'b1;
                    end
                end
                DM_WAIT: begin
                    ext_cs = 1'b1;
                    if (cntZero) begin
                        fetch_en    = 1'b1;
                        decode_en   = 1'b1;
                        execute_en  = 1'b1;
                        execute1_en = 1'b1;
                    end
                end
                PM_WAIT: begin
                    ext_cs = 1'b1;
                    if (!dmExt) begin
                        execute_en  = 1'b1;
                        execute1_en = 1'b1;
                        if (cntZero) begin
                            fetch_en  = 1'b1;
                            decode_en = 1'b1;
                        end else begin
                            bubble = 1'b1;
                        end
                    end
                end
                default: begin
                    ext_cs = 1'b0;
                end
            endcase
        end
    end

    assign ext_add = ext_add_q;
    assign ext_rwb = ext_rwb_q;

endmodule
